// File: rtl/lbr_trace_unit.sv
// Last-branch-record trace unit: circular buffer of taken control transfers
// with filtering, freeze/wrap capture, drop counter, threshold irq and CSR access.
module lbr_trace_unit #(
    parameter  int DATA_WIDTH = 64,
    parameter  int LBR_DEPTH  = 16,
    parameter  int IRQ_THRESH = 16,
    localparam int IDX_W      = $clog2(LBR_DEPTH),
    localparam int ADDR_W     = IDX_W + 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_br_valid,
    input  logic [1:0]            i_br_type,
    input  logic [DATA_WIDTH-1:0] i_br_from,
    input  logic [DATA_WIDTH-1:0] i_br_to,
    input  logic                  i_csr_req,
    input  logic                  i_csr_we,
    input  logic [ADDR_W-1:0]     i_csr_addr,
    input  logic [DATA_WIDTH-1:0] i_csr_wdata,
    output logic [DATA_WIDTH-1:0] o_csr_rdata,
    output logic                  o_csr_ready,
    output logic                  o_irq
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LBR_DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(IRQ_THRESH);
    localparam logic [4:0]       CTRL_RST = 5'b11101;

    logic [4:0]            r_ctrl;
    logic [IDX_W-1:0]      r_tos;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_drop;
    logic [DATA_WIDTH-1:0] r_csr_rdata;
    logic                  r_csr_ready;
    logic                  r_irq;

    logic [DATA_WIDTH-1:0] w_from [LBR_DEPTH];
    logic [DATA_WIDTH-1:0] w_to   [LBR_DEPTH];
    logic [DATA_WIDTH-1:0] w_info [LBR_DEPTH];

    logic                  w_enable, w_freeze;
    logic [2:0]            w_mask;
    logic                  w_ctl_region;
    logic [1:0]            w_ctl_sel, w_field;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_csr_wr, w_csr_rd, w_wr_rec;
    logic                  w_wr_ctrl, w_wr_tos, w_wr_count, w_wr_drop;
    logic                  w_cap_req, w_cap_write, w_cap_drop, w_full;
    logic [IDX_W-1:0]      w_cap_idx;
    logic [CNT_W-1:0]      w_count_next;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_enable     = r_ctrl[0];
    assign w_freeze     = r_ctrl[1];
    assign w_mask       = r_ctrl[4:2];

    assign w_ctl_region = i_csr_addr[ADDR_W-1];
    assign w_ctl_sel    = i_csr_addr[1:0];
    assign w_field      = i_csr_addr[IDX_W+1:IDX_W];
    assign w_idx        = i_csr_addr[IDX_W-1:0];

    assign w_csr_wr     = i_csr_req & i_csr_we;
    assign w_csr_rd     = i_csr_req & ~i_csr_we;
    assign w_wr_rec     = w_csr_wr & ~w_ctl_region;
    assign w_wr_ctrl    = w_csr_wr & w_ctl_region & (w_ctl_sel == 2'd0);
    assign w_wr_tos     = w_csr_wr & w_ctl_region & (w_ctl_sel == 2'd1);
    assign w_wr_count   = w_csr_wr & w_ctl_region & (w_ctl_sel == 2'd2);
    assign w_wr_drop    = w_csr_wr & w_ctl_region & (w_ctl_sel == 2'd3);

    // A TOS load or COUNT clear in the same cycle discards the capture entirely.
    assign w_cap_req    = i_br_valid & ~i_stall & w_enable & (i_br_type != 2'b11)
                        & w_mask[i_br_type] & ~w_wr_tos & ~w_wr_count;
    assign w_full       = (r_count == DEPTH_C);
    assign w_cap_write  = w_cap_req & (~w_full | ~w_freeze);
    assign w_cap_drop   = w_cap_req & w_full & w_freeze;
    assign w_cap_idx    = r_tos + 1'b1;

    always_comb begin
        w_count_next = r_count;
        if (w_wr_count)
            w_count_next = '0;
        else if (w_cap_write && !w_full)
            w_count_next = r_count + 1'b1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < LBR_DEPTH; gi++) begin : g_entry
            localparam logic [IDX_W-1:0] ENTRY = IDX_W'(gi);
            logic [DATA_WIDTH-1:0] r_from;
            logic [DATA_WIDTH-1:0] r_to;
            logic                  r_valid;
            logic [1:0]            r_type;

            // Capture outranks a software write aimed at the same entry.
            always_ff @(posedge i_clock or posedge i_reset) begin
                if (i_reset) begin
                    r_from  <= '0;
                    r_to    <= '0;
                    r_valid <= 1'b0;
                    r_type  <= 2'b00;
                end else if (w_wr_count) begin
                    r_valid <= 1'b0;
                end else if (w_cap_write && (w_cap_idx == ENTRY)) begin
                    r_from  <= i_br_from;
                    r_to    <= i_br_to;
                    r_valid <= 1'b1;
                    r_type  <= i_br_type;
                end else if (w_wr_rec && (w_idx == ENTRY)) begin
                    case (w_field)
                        2'b00:   r_from <= i_csr_wdata;
                        2'b01:   r_to   <= i_csr_wdata;
                        2'b10: begin
                            r_valid <= i_csr_wdata[2];
                            r_type  <= i_csr_wdata[1:0];
                        end
                        default: ;
                    endcase
                end
            end

            assign w_from[gi] = r_from;
            assign w_to[gi]   = r_to;
            assign w_info[gi] = {{(DATA_WIDTH-3){1'b0}}, r_valid, r_type};
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        if (w_ctl_region) begin
            case (w_ctl_sel)
                2'd0:    w_rd_data = {{(DATA_WIDTH-5){1'b0}}, r_ctrl};
                2'd1:    w_rd_data = {{(DATA_WIDTH-IDX_W){1'b0}}, r_tos};
                2'd2:    w_rd_data = {{(DATA_WIDTH-CNT_W){1'b0}}, r_count};
                default: w_rd_data = r_drop;
            endcase
        end else begin
            case (w_field)
                2'b00:   w_rd_data = w_from[w_idx];
                2'b01:   w_rd_data = w_to[w_idx];
                2'b10:   w_rd_data = w_info[w_idx];
                default: w_rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl      <= CTRL_RST;
            r_tos       <= IDX_W'(LBR_DEPTH - 1);
            r_count     <= '0;
            r_drop      <= '0;
            r_csr_rdata <= '0;
            r_csr_ready <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_csr_ready <= i_csr_req;
            r_count     <= w_count_next;
            r_irq       <= (w_count_next >= THRESH_C);
            if (w_csr_rd)
                r_csr_rdata <= w_rd_data;
            if (w_wr_ctrl)
                r_ctrl <= i_csr_wdata[4:0];
            if (w_wr_tos)
                r_tos <= i_csr_wdata[IDX_W-1:0];
            else if (w_cap_write)
                r_tos <= w_cap_idx;
            if (w_wr_drop)
                r_drop <= i_csr_wdata;
            else if (w_cap_drop && (r_drop != {DATA_WIDTH{1'b1}}))
                r_drop <= r_drop + 1'b1;
        end
    end

    assign o_csr_rdata = r_csr_rdata;
    assign o_csr_ready = r_csr_ready;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_lbr_trace_unit.sv
// Directed bench for lbr_trace_unit: CSR read results go through an expected-value
// queue and are checked when csr_ready comes back.
module tb_lbr_trace_unit;

    localparam int DW = 64;
    localparam int AW = 7;

    localparam logic [AW-1:0] A_CTRL  = 7'h40;
    localparam logic [AW-1:0] A_TOS   = 7'h41;
    localparam logic [AW-1:0] A_COUNT = 7'h42;
    localparam logic [AW-1:0] A_DROP  = 7'h43;
    localparam logic [AW-1:0] A_FROM  = 7'h00;
    localparam logic [AW-1:0] A_TO    = 7'h10;
    localparam logic [AW-1:0] A_INFO  = 7'h20;
    localparam logic [AW-1:0] A_RSVD  = 7'h30;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          br_valid;
    logic [1:0]    br_type;
    logic [DW-1:0] br_from, br_to;
    logic          csr_req, csr_we;
    logic [AW-1:0] csr_addr;
    logic [DW-1:0] csr_wdata;
    logic [DW-1:0] csr_rdata;
    logic          csr_ready;
    logic          irq;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q [$];
    string         tag_q [$];

    lbr_trace_unit dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_stall     (stall),
        .i_br_valid  (br_valid),
        .i_br_type   (br_type),
        .i_br_from   (br_from),
        .i_br_to     (br_to),
        .i_csr_req   (csr_req),
        .i_csr_we    (csr_we),
        .i_csr_addr  (csr_addr),
        .i_csr_wdata (csr_wdata),
        .o_csr_rdata (csr_rdata),
        .o_csr_ready (csr_ready),
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic csr_read(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string tag);
        int waited;
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = a;
        tick();
        csr_req = 1'b0;
        waited = 0;
        while (csr_ready !== 1'b1 && waited < 4) begin
            tick();
            waited++;
        end
        chk({tag, "_latency"}, DW'(waited), '0);
        if (csr_ready === 1'b1)
            chk(tag_q.pop_front(), csr_rdata, exp_q.pop_front());
        else begin
            chk({tag_q.pop_front(), "_timeout"}, {63'd0, csr_ready}, 64'd1);
            void'(exp_q.pop_front());
        end
    endtask

    task automatic csr_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        csr_req = 1'b1; csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_req = 1'b0; csr_we = 1'b0;
        chk("wr_ready", {63'd0, csr_ready}, 64'd1);
    endtask

    task automatic cap(input logic [1:0] t, input logic [DW-1:0] f, input logic [DW-1:0] d);
        br_valid = 1'b1; br_type = t; br_from = f; br_to = d;
        tick();
        br_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br_valid = 1'b0; br_type = 2'b00;
        br_from = '0; br_to = '0; csr_req = 1'b0; csr_we = 1'b0;
        csr_addr = '0; csr_wdata = '0;
        tick();
        chk("rst_rdata", csr_rdata, '0);
        chk("rst_ready", {63'd0, csr_ready}, '0);
        chk("rst_irq", {63'd0, irq}, '0);
        tick();
        rst = 1'b0;
        csr_read(A_TOS, 64'd15, "rst_tos");
        csr_read(A_COUNT, 64'd0, "rst_count");
        csr_read(A_DROP, 64'd0, "rst_drop");
        csr_read(A_CTRL, 64'h1D, "rst_ctrl");
        csr_read(A_FROM + 7'd3, 64'd0, "rst_from3");

        // three basic captures
        cap(2'b01, 64'h100, 64'h200);
        cap(2'b00, 64'h204, 64'h180);
        cap(2'b10, 64'h300, 64'h400);
        csr_read(A_TO + 7'd1, 64'h180, "b_to1");
        csr_read(A_INFO + 7'd0, 64'd5, "b_info0");
        csr_read(A_INFO + 7'd1, 64'd4, "b_info1");
        csr_read(A_INFO + 7'd2, 64'd6, "b_info2");
        csr_read(A_FROM + 7'd2, 64'h300, "b_from2");
        csr_read(A_TOS, 64'd2, "b_tos");
        csr_read(A_COUNT, 64'd3, "b_count");
        csr_read(A_RSVD + 7'd1, 64'd0, "b_rsvd");

        // wrap mode, 20 captures
        do_reset();
        for (int i = 0; i < 20; i++) begin
            cap(2'b01, DW'(i), DW'(i + 'h1000));
            chk($sformatf("w_irq%0d", i), {63'd0, irq}, (i >= 15) ? 64'd1 : 64'd0);
        end
        csr_read(A_COUNT, 64'd16, "w_count");
        csr_read(A_TOS, 64'd3, "w_tos");
        csr_read(A_FROM + 7'd0, 64'd16, "w_from0");
        csr_read(A_FROM + 7'd4, 64'd4, "w_from4");
        csr_read(A_DROP, 64'd0, "w_drop");

        // freeze mode, 20 captures
        do_reset();
        csr_write(A_CTRL, 64'h1F);
        for (int i = 0; i < 20; i++)
            cap(2'b01, DW'(i), DW'(i + 'h1000));
        csr_read(A_COUNT, 64'd16, "f_count");
        csr_read(A_TOS, 64'd15, "f_tos");
        csr_read(A_FROM + 7'd0, 64'd0, "f_from0");
        csr_read(A_FROM + 7'd15, 64'd15, "f_from15");
        csr_read(A_DROP, 64'd4, "f_drop");
        chk("f_irq", {63'd0, irq}, 64'd1);
        csr_write(A_DROP, {DW{1'b1}});
        cap(2'b00, 64'h77, 64'h78);
        csr_read(A_DROP, {DW{1'b1}}, "f_drop_sat");

        // COUNT clear collides with a capture that would otherwise be dropped
        csr_write(A_DROP, 64'd5);
        br_valid = 1'b1; br_type = 2'b01; br_from = 64'h999; br_to = 64'h998;
        csr_write(A_COUNT, 64'd0);
        br_valid = 1'b0;
        chk("c_irq", {63'd0, irq}, 64'd0);
        csr_read(A_COUNT, 64'd0, "c_count");
        csr_read(A_INFO + 7'd0, 64'd1, "c_info0");
        csr_read(A_INFO + 7'd9, 64'd1, "c_info9");
        csr_read(A_TOS, 64'd15, "c_tos");
        csr_read(A_DROP, 64'd5, "c_drop");

        // type mask = JAL only, one JAL stalled
        do_reset();
        csr_write(A_CTRL, 64'h09);
        cap(2'b00, 64'h10, 64'h11);
        cap(2'b01, 64'h20, 64'h21);
        cap(2'b10, 64'h30, 64'h31);
        stall = 1'b1;
        cap(2'b01, 64'h40, 64'h41);
        stall = 1'b0;
        cap(2'b00, 64'h50, 64'h51);
        cap(2'b01, 64'h60, 64'h61);
        cap(2'b11, 64'h70, 64'h71);
        csr_read(A_COUNT, 64'd2, "m_count");
        csr_read(A_TOS, 64'd1, "m_tos");
        csr_read(A_FROM + 7'd0, 64'h20, "m_from0");
        csr_read(A_FROM + 7'd1, 64'h60, "m_from1");
        csr_read(A_INFO + 7'd2, 64'd0, "m_info2");

        // save/restore; the TOS write also discards a colliding capture
        csr_write(A_CTRL, 64'h1D);
        br_valid = 1'b1; br_type = 2'b01; br_from = 64'h888; br_to = 64'h889;
        csr_write(A_TOS, 64'd7);
        br_valid = 1'b0;
        csr_read(A_TOS, 64'd7, "s_tos7");
        csr_read(A_COUNT, 64'd2, "s_count2");
        csr_write(A_FROM + 7'd7, 64'hAA);
        csr_write(A_TO + 7'd7, 64'hBB);
        csr_write(A_INFO + 7'd7, 64'b101);
        cap(2'b01, 64'h500, 64'h600);
        csr_read(A_FROM + 7'd8, 64'h500, "s_from8");
        csr_read(A_INFO + 7'd8, 64'd5, "s_info8");
        csr_read(A_FROM + 7'd7, 64'hAA, "s_from7");
        csr_read(A_TO + 7'd7, 64'hBB, "s_to7");
        csr_read(A_INFO + 7'd7, 64'd5, "s_info7");
        csr_read(A_TOS, 64'd8, "s_tos8");
        csr_read(A_COUNT, 64'd3, "s_count3");

        // capture and software write to the same entry: capture wins
        br_valid = 1'b1; br_type = 2'b10; br_from = 64'h700; br_to = 64'h701;
        csr_write(A_FROM + 7'd9, 64'hDEAD);
        br_valid = 1'b0;
        csr_read(A_FROM + 7'd9, 64'h700, "x_from9");

        // reset in the middle of a read aborts it
        csr_req = 1'b1; csr_we = 1'b0; csr_addr = A_FROM + 7'd9; rst = 1'b1;
        tick();
        csr_req = 1'b0;
        tick();
        chk("ra_ready", {63'd0, csr_ready}, 64'd0);
        chk("ra_rdata", csr_rdata, 64'd0);
        rst = 1'b0;
        tick();
        chk("ra_ready2", {63'd0, csr_ready}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
